// File: rtl/dec_bcd_scan.sv
// Multi-digit BCD display scanner: latches a packed BCD word over valid/ready and
// time-multiplexes its digits as one-hot select plus one-hot decode, with optional leading-zero blanking.
module dec_bcd_scan #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 4,
  parameter int LZB    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [9:0]            out,
  output logic                  err,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [4*DIGITS-1:0]   data_r;
  logic [IW-1:0]         idx_r;
  logic [CW-1:0]         cnt_r;
  logic                  err_r;

  logic                  last_s;
  logic                  accept_s;
  logic                  idx_at_max_s;
  logic                  cnt_at_max_s;
  logic [DIGITS-1:0]     lz_s;
  logic [3:0]            nib_s;
  logic                  blank_s;

  function automatic logic nib_invalid(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

  function automatic logic word_invalid(input logic [4*DIGITS-1:0] w);
    logic any;
    any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any = any | nib_invalid(w[i*4 +: 4]);
    end
    return any;
  endfunction

  function automatic logic [9:0] bcd_onehot(input logic [3:0] nib);
    logic [9:0] r;
    r = 10'd0;
    case (nib)
      4'd0:    r = 10'b00_0000_0001;
      4'd1:    r = 10'b00_0000_0010;
      4'd2:    r = 10'b00_0000_0100;
      4'd3:    r = 10'b00_0000_1000;
      4'd4:    r = 10'b00_0001_0000;
      4'd5:    r = 10'b00_0010_0000;
      4'd6:    r = 10'b00_0100_0000;
      4'd7:    r = 10'b00_1000_0000;
      4'd8:    r = 10'b01_0000_0000;
      4'd9:    r = 10'b10_0000_0000;
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  assign idx_at_max_s = (idx_r == IDX_MAX);
  assign cnt_at_max_s = (cnt_r == CNT_MAX);
  assign last_s       = (state_r == ST_SCAN) && idx_at_max_s && cnt_at_max_s;
  assign accept_s     = load_valid && load_ready;
  assign err          = err_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: once scanning, only reset returns the block to idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_valid) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: state_s = ST_SCAN;
      default: state_s = ST_IDLE;
    endcase
  end

  // Word latch, error flag and the digit/dwell counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {(4*DIGITS){1'b0}};
      err_r  <= 1'b0;
      idx_r  <= {IW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (accept_s) begin
      data_r <= load_data;
      err_r  <= word_invalid(load_data);
      idx_r  <= {IW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (state_r == ST_SCAN) begin
      if (cnt_at_max_s) begin
        cnt_r <= {CW{1'b0}};
        idx_r <= idx_at_max_s ? {IW{1'b0}} : (idx_r + IW'(1));
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Leading-zero run: lz_s[i] is set when digit i and all more-significant digits are zero.
  always_comb begin
    logic run;
    run  = 1'b1;
    lz_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run     = run & (data_r[i*4 +: 4] == 4'd0);
      lz_s[i] = run;
    end
  end

  // AND-OR mux of the selected nibble and its blanking condition.
  always_comb begin
    logic hit;
    nib_s   = 4'd0;
    blank_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      hit     = (idx_r == IW'(i));
      nib_s   = nib_s | ({4{hit}} & data_r[i*4 +: 4]);
      blank_s = blank_s | (hit && (LZB != 0) && (i != 0) && lz_s[i]);
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    load_ready = 1'b0;
    digit_sel  = {DIGITS{1'b0}};
    out        = 10'd0;
    frame_done = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_ready = 1'b1;
      end
      ST_SCAN: begin
        for (int i = 0; i < DIGITS; i++) begin
          digit_sel[i] = (idx_r == IW'(i));
        end
        out        = blank_s ? 10'd0 : bcd_onehot(nib_s);
        frame_done = last_s;
        load_ready = last_s;
      end
      default: begin
        load_ready = 1'b1;
      end
    endcase
  end

endmodule
